// File: rtl/riscv_rf_pkg.sv
// Shared constants for the register-file access path.
// Widths, port direction codes and FSM state encoding.
package riscv_rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic RF_READ  = 1'b1;
  localparam logic RF_WRITE = 1'b0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_RD2  = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

endpackage

// File: rtl/rf_operand_slot.sv
// One operand slot: latched source address, capture register,
// read-pending flag and write bypass compare.
import riscv_rf_pkg::*;

module rf_operand_slot (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] start_addr,
  input  logic                  issue,
  input  logic                  drop,
  input  logic [XLEN-1:0]       rdata,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic [REG_ADDR_W-1:0] addr,
  output logic [XLEN-1:0]       value
);

  logic pending;
  logic armed;
  logic hit;

  // Only writes after this slot's read issue can be missed by the read.
  assign hit = armed && wr_en && (wr_addr == addr) && (addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      value   <= '0;
      pending <= 1'b0;
      armed   <= 1'b0;
    end else if (start) begin
      addr    <= start_addr;
      value   <= '0;
      pending <= 1'b0;
      armed   <= 1'b0;
    end else begin
      pending <= issue;
      if (issue)
        armed <= 1'b1;
      else if (drop)
        armed <= 1'b0;
      if (hit)
        value <= wr_data;
      else if (pending)
        value <= (addr == '0) ? '0 : rdata;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences rs1/rs2 reads and rd writebacks over the single
// register-file port; writes always win the port.
import riscv_rf_pkg::*;

module regfile_access_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [REG_ADDR_W-1:0] op_rs1,
  input  logic [REG_ADDR_W-1:0] op_rs2,
  output logic                  opnd_valid,
  input  logic                  opnd_ready,
  output logic [XLEN-1:0]       opnd_rs1_val,
  output logic [XLEN-1:0]       opnd_rs2_val,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  rf_en,
  output logic                  rf_r_or_w,
  output logic [REG_ADDR_W-1:0] rf_read_addr,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [XLEN-1:0]       rf_rdata
);

  logic [2:0]            state;
  logic [2:0]            state_d;
  logic                  wr;
  logic                  accept;
  logic                  issue1;
  logic                  issue2;
  logic                  consume;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;

  assign op_ready   = !reset && (state == S_IDLE);
  assign wb_ready   = !reset;
  assign opnd_valid = (state == S_OUT);

  // x0 writes are consumed but never occupy the port.
  assign wr      = !reset && wb_valid && (wb_rd != '0);
  assign accept  = op_valid && op_ready;
  assign issue1  = (state == S_RD1) && !wr;
  assign issue2  = (state == S_RD2) && !wr;
  assign consume = opnd_valid && opnd_ready;

  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == S_IDLE): if (accept) state_d = S_RD1;
      (state == S_RD1):  if (issue1) state_d = S_RD2;
      (state == S_RD2):  if (issue2) state_d = S_CAP;
      (state == S_CAP):  state_d = S_OUT;
      (state == S_OUT):  if (consume) state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    rf_en         = 1'b0;
    rf_r_or_w     = RF_READ;
    rf_read_addr  = '0;
    rf_write_addr = '0;
    rf_wdata      = '0;
    if (wr) begin
      rf_en         = 1'b1;
      rf_r_or_w     = RF_WRITE;
      rf_write_addr = wb_rd;
      rf_wdata      = wb_data;
    end else if (issue1) begin
      rf_en        = 1'b1;
      rf_read_addr = rs1_q;
    end else if (issue2) begin
      rf_en        = 1'b1;
      rf_read_addr = rs2_q;
    end
  end

  rf_operand_slot u_rs1 (
    .clk        (clk),
    .reset      (reset),
    .start      (accept),
    .start_addr (op_rs1),
    .issue      (issue1),
    .drop       (consume),
    .rdata      (rf_rdata),
    .wr_en      (wr),
    .wr_addr    (wb_rd),
    .wr_data    (wb_data),
    .addr       (rs1_q),
    .value      (opnd_rs1_val)
  );

  rf_operand_slot u_rs2 (
    .clk        (clk),
    .reset      (reset),
    .start      (accept),
    .start_addr (op_rs2),
    .issue      (issue2),
    .drop       (consume),
    .rdata      (rf_rdata),
    .wr_en      (wr),
    .wr_addr    (wb_rd),
    .wr_data    (wb_data),
    .addr       (rs2_q),
    .value      (opnd_rs2_val)
  );

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file plus an
// architectural shadow of all accepted writebacks as reference.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  op_rs1;
  logic [4:0]  op_rs2;
  logic        opnd_valid;
  logic        opnd_ready;
  logic [31:0] opnd_rs1_val;
  logic [31:0] opnd_rs2_val;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_en;
  logic        rf_r_or_w;
  logic [4:0]  rf_read_addr;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem  [32];
  logic [31:0] arch [32];

  logic        q_en, q_rw, q_wr;
  logic [4:0]  q_ra, q_wa, q_rd;
  logic [31:0] q_wd, q_data;

  regfile_access_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_rs1        (op_rs1),
    .op_rs2        (op_rs2),
    .opnd_valid    (opnd_valid),
    .opnd_ready    (opnd_ready),
    .opnd_rs1_val  (opnd_rs1_val),
    .opnd_rs2_val  (opnd_rs2_val),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .rf_en         (rf_en),
    .rf_r_or_w     (rf_r_or_w),
    .rf_read_addr  (rf_read_addr),
    .rf_write_addr (rf_write_addr),
    .rf_wdata      (rf_wdata),
    .rf_rdata      (rf_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]  = '0;
      arch[i] = '0;
    end
    rf_rdata = '0;
    q_en = 1'b0; q_rw = 1'b1; q_wr = 1'b0;
    q_ra = '0; q_wa = '0; q_rd = '0;
    q_wd = '0; q_data = '0;
  end

  // Sample port and writeback at mid-cycle, act on them at the edge.
  always @(negedge clk) begin
    q_en   = rf_en;
    q_rw   = rf_r_or_w;
    q_ra   = rf_read_addr;
    q_wa   = rf_write_addr;
    q_wd   = rf_wdata;
    q_wr   = !reset && wb_valid && (wb_rd != 0);
    q_rd   = wb_rd;
    q_data = wb_data;
  end

  always @(posedge clk) begin
    if (q_en && q_rw)  rf_rdata <= mem[q_ra];
    if (q_en && !q_rw) mem[q_wa] <= q_wd;
    if (q_wr)          arch[q_rd] <= q_data;
  end

  function automatic logic [31:0] ref_val(input logic [4:0] r);
    return (r == 0) ? 32'h0 : arch[r];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [4:0] a, input logic [4:0] b);
    op_valid = 1'b1;
    op_rs1   = a;
    op_rs2   = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wb_one(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (opnd_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume();
    opnd_ready = 1'b1;
    tick();
    opnd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op_valid = 0; op_rs1 = 0; op_rs2 = 0;
    opnd_ready = 0;
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h55;
    @(negedge clk);
    checks++;
    if ({op_ready, wb_ready, rf_en, rf_r_or_w, opnd_valid} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_outs: got %b want 00010",
        {op_ready, wb_ready, rf_en, rf_r_or_w, opnd_valid});
    end
    checks++;
    if ({rf_read_addr, rf_write_addr, rf_wdata} !== 42'h0) begin
      errors++;
      $display("FAIL reset_addrs: got %h want 0",
        {rf_read_addr, rf_write_addr, rf_wdata});
    end
    tick();
    reset = 1'b0;
    wb_valid = 0;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", op_ready);
    end
    issue_op(5'd5, 5'd6);
    tick();
    #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({opnd_valid, rf_en, rf_r_or_w, op_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_mid_rd2: got %b want 0010",
        {opnd_valid, rf_en, rf_r_or_w, op_ready});
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_after: got %b want 1", op_ready);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (opnd_valid) seen++;
        @(negedge clk);
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL reset_discard: got %0d valid cycles want 0", seen);
      end
    end
  endtask

  task automatic test_plain_read();
    int lat;
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h1111_0000;
    @(negedge clk);
    checks++;
    if ({rf_en, rf_r_or_w, rf_write_addr, rf_wdata, wb_ready} !==
        {1'b1, 1'b0, 5'd5, 32'h1111_0000, 1'b1}) begin
      errors++;
      $display("FAIL wr_strobe: got en=%b rw=%b a=%0d d=%h",
        rf_en, rf_r_or_w, rf_write_addr, rf_wdata);
    end
    tick();
    wb_rd = 5'd6; wb_data = 32'h0000_2222;
    tick();
    wb_valid = 0;
    issue_op(5'd5, 5'd6);
    wait_valid(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL plain_latency: got %0d want 4", lat);
    end
    checks++;
    if ({opnd_rs1_val, opnd_rs2_val} !== {32'h1111_0000, 32'h0000_2222}) begin
      errors++;
      $display("FAIL plain_vals: got %h %h want 11110000 00002222",
        opnd_rs1_val, opnd_rs2_val);
    end
    consume();
    @(negedge clk);
    checks++;
    if ({opnd_valid, op_ready} !== 2'b01) begin
      errors++;
      $display("FAIL plain_consume: got %b want 01", {opnd_valid, op_ready});
    end
  endtask

  task automatic test_contention();
    int lat;
    wb_one(5'd8, 32'hA0A0_0008);
    wb_one(5'd9, 32'hB0B0_0009);
    issue_op(5'd8, 5'd9);
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1;
      wb_rd    = (i == 0) ? 5'd8 : (i == 1) ? 5'd10 : 5'd9;
      wb_data  = $urandom;
      @(negedge clk);
      checks++;
      if ({rf_en, rf_r_or_w, rf_write_addr} !== {1'b1, 1'b0, wb_rd}) begin
        errors++;
        $display("FAIL contend_write%0d: got en=%b rw=%b a=%0d",
          i, rf_en, rf_r_or_w, rf_write_addr);
      end
      tick();
    end
    wb_valid = 0;
    wait_valid(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL contend_latency: got %0d want 7", 3 + lat);
    end
    checks++;
    if ({opnd_rs1_val, opnd_rs2_val} !== {ref_val(8), ref_val(9)}) begin
      errors++;
      $display("FAIL contend_vals: got %h %h want %h %h",
        opnd_rs1_val, opnd_rs2_val, ref_val(8), ref_val(9));
    end
    consume();
  endtask

  task automatic test_bypass();
    int lat;
    issue_op(5'd7, 5'd3);
    tick();
    tick();
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_valid = 0;
    @(negedge clk);
    checks++;
    if ({opnd_valid, opnd_rs1_val, opnd_rs2_val} !==
        {1'b1, 32'hDEAD_BEEF, ref_val(3)}) begin
      errors++;
      $display("FAIL bypass_cap: got v=%b %h %h want 1 deadbeef %h",
        opnd_valid, opnd_rs1_val, opnd_rs2_val, ref_val(3));
    end
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'h1234_5678;
    tick();
    wb_valid = 0;
    @(negedge clk);
    checks++;
    if ({opnd_valid, opnd_rs1_val} !== {1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL bypass_out: got v=%b %h want 1 12345678",
        opnd_valid, opnd_rs1_val);
    end
    consume();
    issue_op(5'd12, 5'd13);
    tick();
    wb_valid = 1; wb_rd = 5'd12; wb_data = 32'hA5A5_A5A5;
    tick();
    wb_valid = 0;
    wait_valid(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL coincide_latency: got %0d want 5", 2 + lat);
    end
    checks++;
    if ({opnd_rs1_val, opnd_rs2_val} !== {32'hA5A5_A5A5, ref_val(13)}) begin
      errors++;
      $display("FAIL coincide_vals: got %h %h want a5a5a5a5 %h",
        opnd_rs1_val, opnd_rs2_val, ref_val(13));
    end
    consume();
    issue_op(5'd14, 5'd14);
    tick();
    tick();
    wb_valid = 1; wb_rd = 5'd14; wb_data = 32'h0BAD_F00D;
    tick();
    wb_valid = 0;
    @(negedge clk);
    checks++;
    if ({opnd_valid, opnd_rs1_val, opnd_rs2_val} !==
        {1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL same_rs: got v=%b %h %h want 1 0badf00d x2",
        opnd_valid, opnd_rs1_val, opnd_rs2_val);
    end
    consume();
  endtask

  task automatic test_x0();
    int lat;
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({rf_en, wb_ready} !== 2'b01) begin
      errors++;
      $display("FAIL x0_write: got en=%b ready=%b want 0 1", rf_en, wb_ready);
    end
    tick();
    wb_valid = 0;
    issue_op(5'd0, 5'd0);
    wait_valid(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL x0_latency: got %0d want 4", lat);
    end
    checks++;
    if ({opnd_rs1_val, opnd_rs2_val} !== 64'h0) begin
      errors++;
      $display("FAIL x0_vals: got %h %h want 0 0", opnd_rs1_val, opnd_rs2_val);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    issue_op(5'd5, 5'd6);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      if ({opnd_valid, op_ready, opnd_rs1_val, opnd_rs2_val} !==
          {2'b10, 32'h1111_0000, 32'h0000_2222})
        bad++;
      tick();
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || lat != 4) begin
      errors++;
      $display("FAIL backpressure: got %0d unstable cycles lat=%0d want 0 4",
        bad, lat);
    end
    consume();
    @(negedge clk);
    checks++;
    if ({opnd_valid, op_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got %b want 01", {opnd_valid, op_ready});
    end
  endtask

  task automatic test_random();
    logic       pend = 1'b0;
    logic [4:0] e1 = '0;
    logic [4:0] e2 = '0;
    int age = 0;
    int acc = 0;
    int del = 0;
    tick();
    for (int c = 0; c < 800; c++) begin
      wb_valid   = ($urandom % 100) < 40;
      wb_rd      = 5'($urandom % 8);
      wb_data    = $urandom;
      op_valid   = ($urandom % 2) == 1;
      op_rs1     = 5'($urandom % 8);
      op_rs2     = 5'($urandom % 8);
      opnd_ready = ($urandom % 3) != 0;
      @(negedge clk);
      if (wb_valid && wb_rd != 0) begin
        checks++;
        if ({wb_ready, rf_en, rf_r_or_w, rf_write_addr, rf_wdata} !==
            {2'b11, 1'b0, wb_rd, wb_data}) begin
          errors++;
          $display("FAIL rnd_write c=%0d: got rdy=%b en=%b rw=%b a=%0d d=%h",
            c, wb_ready, rf_en, rf_r_or_w, rf_write_addr, rf_wdata);
        end
      end
      if (opnd_valid) begin
        checks++;
        if ({pend, opnd_rs1_val, opnd_rs2_val} !==
            {1'b1, ref_val(e1), ref_val(e2)}) begin
          errors++;
          $display("FAIL rnd_opnd c=%0d x%0d x%0d: got %h %h want %h %h",
            c, e1, e2, opnd_rs1_val, opnd_rs2_val, ref_val(e1), ref_val(e2));
        end
        if (opnd_ready) begin
          pend = 1'b0;
          del++;
        end
      end
      if (op_valid && op_ready) begin
        checks++;
        if (pend !== 1'b0) begin
          errors++;
          $display("FAIL rnd_accept c=%0d: got accept with pending want none", c);
        end
        pend = 1'b1;
        e1 = op_rs1;
        e2 = op_rs2;
        age = 0;
        acc++;
      end
      if (pend) age++;
      if (age > 30) begin
        errors++;
        checks++;
        $display("FAIL rnd_timeout c=%0d: got no delivery want <=30 cycles", c);
        break;
      end
      tick();
    end
    wb_valid = 0; op_valid = 0; opnd_ready = 1;
    tick(); tick(); tick(); tick(); tick();
    opnd_ready = 0;
    checks++;
    if (acc < 20 || (acc - del) > 1) begin
      errors++;
      $display("FAIL rnd_counts: got acc=%0d del=%0d want >=20 and equal",
        acc, del);
    end
  endtask

  initial begin
    test_reset();
    test_plain_read();
    test_contention();
    test_bypass();
    test_x0();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
